// File: rtl/eth_fifo_ctrl_pkg.sv
// Shared widths, levels and flag helper for the Ethernet FWFT FIFO controller.
package eth_fifo_ctrl_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_DEPTH      = 16;
    localparam int FIFO_PTR_WIDTH  = 4;
    localparam int FIFO_CNT_WIDTH  = 5;
    localparam int FIFO_AF_LEVEL   = 14;
    localparam int FIFO_AE_LEVEL   = 1;

    typedef logic [FIFO_DATA_WIDTH-1:0] word_t;
    typedef logic [FIFO_PTR_WIDTH-1:0]  ptr_t;
    typedef logic [FIFO_CNT_WIDTH-1:0]  cnt_t;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, almost_full: 1'b0,
                                           empty: 1'b1, almost_empty: 1'b1};

    function automatic fifo_flags_t calc_flags(input cnt_t c, input cnt_t af, input cnt_t ae);
        fifo_flags_t f;
        f.full         = (c == cnt_t'(FIFO_DEPTH));
        f.almost_full  = (c >= af);
        f.empty        = (c == '0);
        f.almost_empty = (c <= ae);
        return f;
    endfunction

endpackage

// File: rtl/eth_fifo_if.sv
// Push/pop request and status bundle between a FIFO user and eth_fifo_ctrl.
interface eth_fifo_if
    import eth_fifo_ctrl_pkg::*;
();
    logic  clear;
    logic  write;
    word_t data_in;
    logic  read;
    word_t data_out;
    logic  full;
    logic  almost_full;
    logic  empty;
    logic  almost_empty;
    cnt_t  cnt;
    logic  overflow;
    logic  underflow;

    modport master (
        output clear, write, data_in, read,
        input  data_out, full, almost_full, empty, almost_empty, cnt, overflow, underflow
    );

    modport slave (
        input  clear, write, data_in, read,
        output data_out, full, almost_full, empty, almost_empty, cnt, overflow, underflow
    );
endinterface

// File: rtl/eth_fifo_ctrl_ram.sv
// Behavioural distributed RAM: synchronous write, asynchronous read.
module eth_fifo_ctrl_ram #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/eth_fifo_ctrl.sv
// First-word-fall-through FIFO controller: pointers, occupancy, registered flags
// and sticky error bits around a 16x32 distributed RAM.
module eth_fifo_ctrl
    import eth_fifo_ctrl_pkg::*;
#(
    parameter int AF_LEVEL = FIFO_AF_LEVEL,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic      clk,
    input  logic      reset_n,
    eth_fifo_if.slave bus
);
    localparam cnt_t AF_CNT = cnt_t'(AF_LEVEL);
    localparam cnt_t AE_CNT = cnt_t'(AE_LEVEL);

    logic        w_push_ok;
    logic        w_pop_ok;
    ptr_t        r_wr_ptr;
    ptr_t        r_rd_ptr;
    cnt_t        r_cnt;
    cnt_t        w_cnt_next;
    fifo_flags_t r_flags;
    fifo_flags_t w_flags_next;
    logic        r_overflow;
    logic        r_underflow;
    word_t       w_rd_data;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts write+read.
    assign w_push_ok = bus.write & (~r_flags.full | bus.read) & ~bus.clear;
    assign w_pop_ok  = bus.read & ~r_flags.empty & ~bus.clear;

    always_comb begin
        w_cnt_next = r_cnt;
        if (bus.clear) begin
            w_cnt_next = '0;
        end else if (w_push_ok && !w_pop_ok) begin
            w_cnt_next = r_cnt + 1'b1;
        end else if (w_pop_ok && !w_push_ok) begin
            w_cnt_next = r_cnt - 1'b1;
        end
        w_flags_next = calc_flags(w_cnt_next, AF_CNT, AE_CNT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_flags     <= FLAGS_RESET;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_flags <= w_flags_next;
            if (bus.clear) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (bus.write && r_flags.full && !bus.read) r_overflow  <= 1'b1;
                if (bus.read && r_flags.empty)              r_underflow <= 1'b1;
            end
        end
    end

`ifdef ETH_FIFO_XILINX
    xilinx_dist_ram_16x32 u_ram (
        .data_out      (w_rd_data),
        .we            (w_push_ok),
        .data_in       (bus.data_in),
        .read_address  (r_rd_ptr),
        .write_address (r_wr_ptr),
        .wclk          (clk)
    );
`else
    eth_fifo_ctrl_ram #(
        .DW (FIFO_DATA_WIDTH),
        .AW (FIFO_PTR_WIDTH)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );
`endif

    assign bus.data_out     = w_rd_data;
    assign bus.cnt          = r_cnt;
    assign bus.full         = r_flags.full;
    assign bus.almost_full  = r_flags.almost_full;
    assign bus.empty        = r_flags.empty;
    assign bus.almost_empty = r_flags.almost_empty;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_eth_fifo_ctrl.sv
// Scoreboard bench for eth_fifo_ctrl: stimulus queues the expected post-edge state,
// a monitor pops and compares one entry after each rising edge.
module tb_eth_fifo_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    eth_fifo_if bus ();

    eth_fifo_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          step;
        logic [4:0]  cnt;
        logic        ov;
        logic        un;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step   = 0;

    task automatic chk(input string name, input int stp, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step=%0d got=%h want=%h", name, stp, act, req);
        end
    endtask

    task automatic cmp_all(input exp_t e);
        chk("cnt",          e.step, 32'(bus.cnt),      32'(e.cnt));
        chk("full",         e.step, 32'(bus.full),     32'(e.cnt == 5'd16));
        chk("almost_full",  e.step, 32'(bus.almost_full),  32'(e.cnt >= 5'd14));
        chk("empty",        e.step, 32'(bus.empty),    32'(e.cnt == 5'd0));
        chk("almost_empty", e.step, 32'(bus.almost_empty), 32'(e.cnt <= 5'd1));
        chk("overflow",     e.step, 32'(bus.overflow), 32'(e.ov));
        chk("underflow",    e.step, 32'(bus.underflow), 32'(e.un));
        if (e.chk_data) chk("data_out", e.step, bus.data_out, e.data);
    endtask

    function automatic exp_t mk(input int c, input logic ov, input logic un,
                                input logic cd, input logic [31:0] d);
        exp_t e;
        step++;
        e.step = step; e.cnt = 5'(c); e.ov = ov; e.un = un; e.chk_data = cd; e.data = d;
        return e;
    endfunction

    // One clock of stimulus plus the state expected right after the following edge.
    task automatic cycle(input logic clr, input logic wr, input logic [31:0] din, input logic rd,
                         input int c, input logic ov, input logic un,
                         input logic cd, input logic [31:0] d);
        @(negedge clk);
        bus.clear = clr; bus.write = wr; bus.data_in = din; bus.read = rd;
        sb.push_back(mk(c, ov, un, cd, d));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp_all(e);
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "timeout");
    end

    logic [31:0] q5 [16];

    initial begin : stimulus
        bus.clear = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1 cmp_all(mk(0, 0, 0, 0, 0));
        @(negedge clk) reset_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill, then one push too many.
        for (int i = 0; i < 16; i++) cycle(0, 1, 32'(i), 0, i + 1, 0, 0, 1, 32'h0);
        cycle(0, 1, 32'h99, 0, 16, 1, 0, 1, 32'h0);

        // Drain in order, then one pop too many.
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 15 - i, 1, 0, i < 15, 32'(i + 1));
        cycle(0, 0, 0, 1, 0, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) cycle(0, 1, 32'h100 + 32'(i), 0, i + 1, 0, 0, 1, 32'h100);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 9 - i, 0, 0, i < 9, 32'h100 + 32'(i + 1));
        for (int i = 0; i < 16; i++) cycle(0, 1, 32'hA5A5_0000 + 32'(i), 0, i + 1, 0, 0, 1, 32'hA5A5_0000);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 15 - i, 0, 0, i < 15, 32'hA5A5_0000 + 32'(i + 1));

        // Simultaneous write+read at full, then at empty.
        for (int i = 0; i < 15; i++) q5[i] = 32'hB1 + 32'(i);
        q5[15] = 32'hCC;
        for (int i = 0; i < 16; i++) cycle(0, 1, 32'hB0 + 32'(i), 0, i + 1, 0, 0, 1, 32'hB0);
        cycle(0, 1, 32'hCC, 1, 16, 0, 0, 1, q5[0]);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) cycle(0, 0, 0, 1, 15 - i, 0, 0, 1, q5[i + 1]);
            else        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        end
        cycle(0, 1, 32'hDEAD_BEEF, 1, 1, 0, 1, 1, 32'hDEAD_BEEF);
        cycle(0, 0, 0, 1, 0, 0, 1, 0, 0);

        // clear beats write+read at cnt=7 and drops the sticky underflow.
        for (int i = 0; i < 7; i++) cycle(0, 1, 32'h70 + 32'(i), 0, i + 1, 0, 1, 1, 32'h70);
        cycle(1, 1, 32'h55, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'h50 + 32'(i), 0, i + 1, 0, 0, 1, 32'h50);
        @(negedge clk);
        bus.write = 1'b1; bus.data_in = 32'h99;
        #2 reset_n = 1'b0;
        #1 cmp_all(mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1 cmp_all(mk(0, 0, 0, 0, 0));
        @(negedge clk);
        bus.write = 1'b0;
        reset_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h1234_5678, 0, 1, 0, 0, 1, 32'h1234_5678);
        cycle(0, 0, 0, 0, 1, 0, 0, 1, 32'h1234_5678);

        repeat (2) @(negedge clk);
        chk("sb_drain", step, 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
